// File: rtl/bus_initiator_if.sv
// Handshake bundle for bus_initiator: core load/store request/response plus the
// split read (address/data) and write (data+address/response) bus channels.
interface bus_initiator_if #(
  parameter int BUS_WIDTH  = 32,
  parameter int RESP_WIDTH = 2
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [BUS_WIDTH-1:0]   req_addr;
  logic [BUS_WIDTH-1:0]   req_wdata;
  logic [1:0]             req_size;
  logic                   req_unsigned;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [BUS_WIDTH-1:0]   rsp_rdata;
  logic                   rsp_err;

  logic                   dr_addr_valid;
  logic                   dr_addr_ready;
  logic [BUS_WIDTH-1:0]   dr_addr;
  logic                   dr_data_valid;
  logic                   dr_data_ready;
  logic [BUS_WIDTH-1:0]   dr_data;

  logic                   dw_data_addr_valid;
  logic                   dw_data_addr_ready;
  logic [BUS_WIDTH-1:0]   dw_addr;
  logic [BUS_WIDTH-1:0]   dw_data;
  logic [BUS_WIDTH/8-1:0] dw_strobe;
  logic                   dw_resp_valid;
  logic                   dw_resp_ready;
  logic [RESP_WIDTH-1:0]  dw_resp;

  // Initiator view
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output dr_addr_valid, dr_addr, dr_data_ready,
    input  dr_addr_ready, dr_data_valid, dr_data,
    output dw_data_addr_valid, dw_addr, dw_data, dw_strobe, dw_resp_ready,
    input  dw_data_addr_ready, dw_resp_valid, dw_resp
  );

  // Core + memory responder view
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  dr_addr_valid, dr_addr, dr_data_ready,
    output dr_addr_ready, dr_data_valid, dr_data,
    input  dw_data_addr_valid, dw_addr, dw_data, dw_strobe, dw_resp_ready,
    output dw_data_addr_ready, dw_resp_valid, dw_resp
  );
endinterface

// File: rtl/bus_initiator.sv
// Single-outstanding load/store master for the split data bus; all outputs registered.
// Optional macro MISALIGN_TRAP_EN: misaligned half/word requests error out without a bus access.
module bus_initiator #(
  parameter int                    BUS_WIDTH  = 32,
  parameter int                    RESP_WIDTH = 2,
  parameter logic [RESP_WIDTH-1:0] RESP_OK    = '0
) (
  input logic             clk,
  input logic             rst,
  bus_initiator_if.master bus
);
  localparam int STRB_W = BUS_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP} state_t;

  state_t               state_q;
  logic                 req_ready_q;
  logic                 rsp_valid_q;
  logic [BUS_WIDTH-1:0] rsp_rdata_q;
  logic                 rsp_err_q;
  logic                 dr_addr_valid_q;
  logic [BUS_WIDTH-1:0] dr_addr_q;
  logic                 dr_data_ready_q;
  logic                 dw_valid_q;
  logic [BUS_WIDTH-1:0] dw_addr_q;
  logic [BUS_WIDTH-1:0] dw_data_q;
  logic [STRB_W-1:0]    dw_strobe_q;
  logic                 dw_resp_ready_q;
  logic [1:0]           size_q;
  logic                 uns_q;
  logic [1:0]           lane_q;

  logic [1:0]           lane_d;
  logic [STRB_W-1:0]    strobe_d;
  logic [BUS_WIDTH-1:0] wdata_d;
  logic [BUS_WIDTH-1:0] addr_d;
  logic                 misalign_d;
  logic [BUS_WIDTH-1:0] rdata_sh;
  logic [BUS_WIDTH-1:0] rdata_ext;

  // Lane is the byte offset inside the word; low bits below the access size are dropped.
  always_comb begin
    lane_d   = 2'b00;
    strobe_d = '1;
    case (bus.req_size)
      2'd0: begin
        lane_d   = bus.req_addr[1:0];
        strobe_d = STRB_W'(4'b0001) << bus.req_addr[1:0];
      end
      2'd1: begin
        lane_d   = {bus.req_addr[1], 1'b0};
        strobe_d = STRB_W'(4'b0011) << {bus.req_addr[1], 1'b0};
      end
      default: ;
    endcase
  end

  assign wdata_d = bus.req_wdata << {lane_d, 3'b000};
  assign addr_d  = {bus.req_addr[BUS_WIDTH-1:2], 2'b00};

`ifdef MISALIGN_TRAP_EN
  assign misalign_d = ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                      (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`else
  assign misalign_d = 1'b0;
`endif

  assign rdata_sh = bus.dr_data >> {lane_q, 3'b000};

  always_comb begin
    rdata_ext = rdata_sh;
    case (size_q)
      2'd0: rdata_ext = {{(BUS_WIDTH-8){~uns_q & rdata_sh[7]}}, rdata_sh[7:0]};
      2'd1: rdata_ext = {{(BUS_WIDTH-16){~uns_q & rdata_sh[15]}}, rdata_sh[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= IDLE;
      req_ready_q     <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= '0;
      rsp_err_q       <= 1'b0;
      dr_addr_valid_q <= 1'b0;
      dr_addr_q       <= '0;
      dr_data_ready_q <= 1'b0;
      dw_valid_q      <= 1'b0;
      dw_addr_q       <= '0;
      dw_data_q       <= '0;
      dw_strobe_q     <= '0;
      dw_resp_ready_q <= 1'b0;
      size_q          <= 2'd0;
      uns_q           <= 1'b0;
      lane_q          <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (bus.req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            size_q      <= bus.req_size;
            uns_q       <= bus.req_unsigned;
            lane_q      <= lane_d;
            if (misalign_d) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
              state_q     <= RSP;
            end else if (bus.req_write) begin
              dw_valid_q  <= 1'b1;
              dw_addr_q   <= addr_d;
              dw_data_q   <= wdata_d;
              dw_strobe_q <= strobe_d;
              state_q     <= WR_REQ;
            end else begin
              dr_addr_valid_q <= 1'b1;
              dr_addr_q       <= addr_d;
              state_q         <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (bus.dr_addr_ready) begin
            dr_addr_valid_q <= 1'b0;
            dr_data_ready_q <= 1'b1;
            state_q         <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (bus.dr_data_valid) begin
            dr_data_ready_q <= 1'b0;
            rsp_rdata_q     <= rdata_ext;
            rsp_err_q       <= 1'b0;
            rsp_valid_q     <= 1'b1;
            state_q         <= RSP;
          end
        end
        WR_REQ: begin
          if (bus.dw_data_addr_ready) begin
            dw_valid_q      <= 1'b0;
            dw_resp_ready_q <= 1'b1;
            state_q         <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bus.dw_resp_valid) begin
            dw_resp_ready_q <= 1'b0;
            rsp_err_q       <= (bus.dw_resp != RESP_OK);
            rsp_rdata_q     <= '0;
            rsp_valid_q     <= 1'b1;
            state_q         <= RSP;
          end
        end
        RSP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready          = req_ready_q;
  assign bus.rsp_valid          = rsp_valid_q;
  assign bus.rsp_rdata          = rsp_rdata_q;
  assign bus.rsp_err            = rsp_err_q;
  assign bus.dr_addr_valid      = dr_addr_valid_q;
  assign bus.dr_addr            = dr_addr_q;
  assign bus.dr_data_ready      = dr_data_ready_q;
  assign bus.dw_data_addr_valid = dw_valid_q;
  assign bus.dw_addr            = dw_addr_q;
  assign bus.dw_data            = dw_data_q;
  assign bus.dw_strobe          = dw_strobe_q;
  assign bus.dw_resp_ready      = dw_resp_ready_q;
endmodule
